// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings for the op[1:0] input of mult_div_unit
//   - FSM state type
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mduState_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate.
// Ports:
//   negate  in  1  when high, result = -value
//   value   in  N  operand
//   result  out N  value or its two's complement
module mdu_sign_fix #(
  parameter int N = 32
) (
  input  logic         negate,
  input  logic [N-1:0] value,
  output logic [N-1:0] result
);

  assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide with HI/LO result registers.
// One result bit per cycle; mult is shift-add on magnitudes, div is
// restoring division on magnitudes, signs are fixed up in FIN.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request, sampled only in IDLE
//   op        in   op[0]: 0 mult / 1 div; op[1]: unsigned (macro only)
//   op_a      in   multiplicand / dividend
//   op_b      in   multiplier / divisor
//   busy      out  state != IDLE
//   done      out  one-cycle pulse, hi/lo valid while high
//   hi        out  product upper half / remainder
//   lo        out  product lower half / quotient
//   div_zero  out  last div had a zero divisor
// Build option: define MULT_DIV_UNSIGNED_EN to enable multu/divu via op[1].
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// RUN   | one shift-add / restoring-divide step per cycle
// FIN   | sign fix-up, write hi/lo (or flag divide-by-zero), pulse done
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  mduState_e          state;
  logic [CW-1:0]      count;
  // mult: {partial product, remaining multiplier bits}
  // div:  {partial remainder, remaining dividend bits / quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               isDiv;
  logic               signA;
  logic               signB;
  logic               zeroDiv;

  logic               unsignedOp;
  logic               opSignA;
  logic               opSignB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

`ifdef MULT_DIV_UNSIGNED_EN
  assign unsignedOp = op[1];
`else
  logic unusedOpBit;
  assign unusedOpBit = op[1];
  assign unsignedOp  = 1'b0;
`endif

  assign opSignA = ~unsignedOp & op_a[WIDTH-1];
  assign opSignB = ~unsignedOp & op_b[WIDTH-1];
  assign magA    = opSignA ? (~op_a + 1'b1) : op_a;
  assign magB    = opSignB ? (~op_b + 1'b1) : op_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right keeping the carry.
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Restoring step: the shifted remainder needs WIDTH+1 bits for the compare,
  // but after a successful subtract it always fits back into WIDTH bits.
  logic [WIDTH:0]     remShift;
  logic               remGe;
  logic [WIDTH-1:0]   remDiff;
  logic [2*WIDTH-1:0] divNext;
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign remGe    = remShift >= {1'b0, operand};
  assign remDiff  = remShift[WIDTH-1:0] - operand;
  assign divNext  = {(remGe ? remDiff : remShift[WIDTH-1:0]), acc[WIDTH-2:0], remGe};

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  mdu_sign_fix #(.N(2*WIDTH)) uProdFix (
    .negate(signA ^ signB),
    .value (acc),
    .result(prodFix)
  );

  mdu_sign_fix #(.N(WIDTH)) uQuotFix (
    .negate(signA ^ signB),
    .value (acc[WIDTH-1:0]),
    .result(quotFix)
  );

  // Remainder follows the dividend sign so division truncates toward zero.
  mdu_sign_fix #(.N(WIDTH)) uRemFix (
    .negate(signA),
    .value (acc[2*WIDTH-1:WIDTH]),
    .result(remFix)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      isDiv    <= 1'b0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      zeroDiv  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv <= op[0];
            signA <= opSignA;
            signB <= opSignB;
            count <= CW'(WIDTH);
            if (op[0]) begin
              acc     <= {{WIDTH{1'b0}}, magA};
              operand <= magB;
            end else begin
              acc     <= {{WIDTH{1'b0}}, magB};
              operand <= magA;
            end
            if (op[0] && (op_b == '0)) begin
              zeroDiv <= 1'b1;
              state   <= FIN;
            end else begin
              zeroDiv <= 1'b0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIN;
        end
        FIN: begin
          if (zeroDiv) begin
            div_zero <= 1'b1;
          end else begin
            div_zero <= 1'b0;
            if (isDiv) begin
              hi <= remFix;
              lo <= quotFix;
            end else begin
              hi <= prodFix[2*WIDTH-1:WIDTH];
              lo <= prodFix[WIDTH-1:0];
            end
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with HI/LO result registers for the multi-cycle MIPS datapath. It replaces the separate fixed-width Div/Mult blocks and their HI/LO select muxes. It takes two WIDTH-bit operands and computes one result bit per cycle. It reports completion through a one-cycle done pulse for the control unit, and flags divide-by-zero as an exception source.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 2.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  op[0]: 0 = mult, 1 = div; op[1]: 1 = unsigned (see Configuration).
- op_a  in  WIDTH  multiplicand / dividend (RegA).
- op_b  in  WIDTH  multiplier / divisor (RegB).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  registered one-cycle pulse; hi/lo valid while high.
- hi  out  WIDTH  mult: upper half of product; div: remainder.
- lo  out  WIDTH  mult: lower half of product; div: quotient.
- div_zero  out  1  registered; set at the end of a div with op_b = 0.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - start = 1 latches the operands and sign flags (op_a MSB, op_b MSB, signed ops only).
  - Magnitudes are loaded into the datapath and the counter is set to WIDTH.
  - Next state is RUN.
  - Exception: div with op_b = 0 goes straight to FIN with the zero flag set.
- RUN:
  - mult: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
  - div: restoring division; shift remainder left, subtract divisor, keep the result if non-negative, shift in one quotient bit.
  - The counter decrements each cycle. Leave RUN when the counter reaches 1.
- FIN:
  - Sign fix-up:
    - product negated if sa ^ sb;
    - quotient negated if sa ^ sb;
    - remainder takes the sign of sa.
  - hi/lo are written and done is set; next state is IDLE.
  - Divide-by-zero: hi/lo are NOT written and div_zero = 1.
  - Any other op: div_zero = 0.
- Division truncates toward zero, so -7/2 gives q = -3, r = -1.
- MIN / -1 wraps: lo = MIN, hi = 0. No overflow is flagged.
- start while busy is ignored and has no side effects.
- hi/lo hold their values between operations.
- Operands are captured at accept, so op_a and op_b may change after that cycle.

## Timing
- Start sampled at the end of cycle 0.
- Cycles 1..WIDTH: RUN. Cycle WIDTH+1: FIN. Cycle WIDTH+2: done = 1, hi/lo valid, state IDLE.
- Divide-by-zero: cycle 1 is FIN, done = 1 in cycle 2.
- busy is high for cycles 1..WIDTH+1 (cycle 1 only for divide-by-zero).
- A start in the done cycle is accepted, giving back-to-back ops with a period of WIDTH+2.
- Reset, including mid-RUN or mid-FIN:
  - state IDLE;
  - busy, done, div_zero = 0;
  - hi, lo = 0;
  - the counter and datapath are cleared;
  - any in-flight result is discarded.
- reset has priority over start in the same cycle.

## Configuration
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined:
  - op[1] = 1 selects multu/divu;
  - sign flags are forced to 0 and operands are used raw;
  - FIN skips the sign fix-up.
- Undefined:
  - op[1] is ignored and every op is signed;
  - the unsigned select logic is not compiled.

## Structure
- Package mdu_pkg holds:
  - op encodings as localparams: OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MULTU = 2'b10, OP_DIVU = 2'b11;
  - the state enum (IDLE, RUN, FIN).
- Counter width is $clog2(WIDTH+1).
- One sub-module, mdu_sign_fix: a combinational conditional two's-complement negate of width N, instantiated for the product, quotient and remainder.
- The single FSM and datapath stay in mult_div_unit.

## Test plan
All scenarios use WIDTH = 32.
- mult 7 × -3 (0xFFFFFFFD) → done in cycle 34, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0.
- div -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Following a completed op (hi = 0x11, lo = 0x22), div 5 / 0 → done in cycle 2, div_zero = 1, hi = 0x11 and lo = 0x22 unchanged. A following mult clears div_zero.
- start pulsed in cycles 5 and 20 during a mult → ignored, single result. A new start in the done cycle → second done exactly 34 cycles later.
- reset asserted in cycle 10 of a div → next cycle busy = done = div_zero = 0, hi = lo = 0. No done pulse follows.
- op = 2'b10, 0xFFFFFFFF × 2:
  - with MULT_DIV_UNSIGNED_EN → hi = 0x00000001, lo = 0xFFFFFFFE;
  - without → hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
